// File: rtl/aes_round_ctrl_if.sv
// Handshake and control bundle between the AES round sequencer and its
// environment: request/response handshakes, key-expansion requests and
// datapath strobes.
// The master modport is the environment side. The slave modport is the
// controller side.
interface aes_round_ctrl_if;

    // Block request from the producer
    logic       in_valid;
    logic       in_ready;
    logic [2:0] key_len;

    // Round-key exchange with the key-expansion unit
    logic       rk_req;
    logic [3:0] rk_idx;
    logic       rk_ack;

    // Datapath strobes
    logic       dp_load;
    logic       dp_round_en;
    logic       dp_final;

    // Result handshake and status
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       err;

    modport master (
        output in_valid,
        output key_len,
        output rk_ack,
        output out_ready,
        input  in_ready,
        input  rk_req,
        input  rk_idx,
        input  dp_load,
        input  dp_round_en,
        input  dp_final,
        input  out_valid,
        input  busy,
        input  err
    );

    modport slave (
        input  in_valid,
        input  key_len,
        input  rk_ack,
        input  out_ready,
        output in_ready,
        output rk_req,
        output rk_idx,
        output dp_load,
        output dp_round_en,
        output dp_final,
        output out_valid,
        output busy,
        output err
    );

endinterface

// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES encryption datapath.
// A block request is accepted in IDLE, and the round count Nr is taken from key_len.
// KEY_WAIT asks for round keys 0..Nr one at a time. Each acknowledged key
// strobes the datapath: the load for key 0 and a round enable for keys 1..Nr.
// The final round also raises dp_final, which bypasses MixColumns.
// DONE presents out_valid until the consumer takes the result.
//
// Optional feature: define AES_RC_TIMEOUT_EN to abort a block when the
// key-expansion unit leaves a request unacknowledged for TIMEOUT_CYCLES cycles.
module aes_round_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic              clk,
    input logic              reset,
    aes_round_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle,
        StKeyWait,
        StDone
    } state_e;

    // Nr from key_len, with the larger key taking priority. Zero never reaches here.
    function automatic logic [3:0] nr_from_key_len(logic [2:0] kl);
        if (kl[2]) begin
            return 4'd14;
        end else if (kl[1]) begin
            return 4'd12;
        end else begin
            return 4'd10;
        end
    endfunction

    // Reject out-of-range timeout settings at elaboration
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..255");
    end

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [3:0] nr_q, nr_d;
    logic       err_q, err_d;
    logic       key_fire;

`ifdef AES_RC_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
`endif

    assign key_fire = (state_q == StKeyWait) && bus.rk_ack;

    // State, round, key length and error pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            round_q <= 4'd0;
            nr_q    <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            nr_q    <= nr_d;
            err_q   <= err_d;
        end
    end

`ifdef AES_RC_TIMEOUT_EN
    // Key-wait timeout counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Next-state logic: acceptance, round stepping and result handshake
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        nr_d    = nr_q;
        err_d   = 1'b0;
`ifdef AES_RC_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    if (bus.key_len != 3'b000) begin
                        nr_d    = nr_from_key_len(bus.key_len);
                        round_d = 4'd0;
                        state_d = StKeyWait;
`ifdef AES_RC_TIMEOUT_EN
                        cnt_d   = 8'd0;
`endif
                    end else begin
                        // An invalid request is still consumed and only flagged.
                        err_d = 1'b1;
                    end
                end
            end

            StKeyWait: begin
                if (bus.rk_ack) begin
`ifdef AES_RC_TIMEOUT_EN
                    cnt_d = 8'd0;
`endif
                    if (round_q == nr_q) begin
                        state_d = StDone;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end else begin
`ifdef AES_RC_TIMEOUT_EN
                    if (cnt_q == TimeoutLast) begin
                        // Abandon the block. No result is produced for it.
                        state_d = StIdle;
                        round_d = 4'd0;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
`endif
                end
            end

            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                    round_d = 4'd0;
                end
            end

            default: begin
                state_d = StIdle;
                round_d = 4'd0;
            end
        endcase
    end

    // Handshake outputs and datapath strobes
    always_comb begin
        bus.in_ready    = (state_q == StIdle);
        bus.busy        = (state_q != StIdle);
        bus.out_valid   = (state_q == StDone);
        bus.rk_req      = (state_q == StKeyWait);
        bus.rk_idx      = (state_q == StKeyWait) ? round_q : 4'd0;
        bus.dp_load     = key_fire && (round_q == 4'd0);
        bus.dp_round_en = key_fire && (round_q != 4'd0);
        bus.dp_final    = key_fire && (round_q != 4'd0) && (round_q == nr_q);
        bus.err         = err_q;
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl. Each block is walked cycle by cycle
// against hand-derived round/strobe expectations.
module tb_aes_round_ctrl;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    aes_round_ctrl_if bus ();

    aes_round_ctrl #(
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one block and follow it to completion.
    // During round stall_round, rk_ack is held low for stall_n cycles.
    // After out_valid rises, out_ready is held low for hold cycles.
    task automatic run_block(input logic [2:0] kl, input int nr, input int stall_round,
                             input int stall_n, input int hold);
        int   round;
        int   stalls;
        logic ack;
        round  = 0;
        stalls = 0;
        bus.in_valid  = 1'b1;
        bus.key_len   = kl;
        bus.rk_ack    = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        check("accept_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        bus.key_len  = 3'b000;  // ignored after acceptance
        while (round <= nr) begin
            ack = !(round == stall_round && stalls < stall_n);
            bus.rk_ack = ack;
            #1;
            check("rk_req", bus.rk_req, 1);
            check("rk_idx", bus.rk_idx, round);
            check("dp_load", bus.dp_load, ack && round == 0);
            check("dp_round_en", bus.dp_round_en, ack && round != 0);
            check("dp_final", bus.dp_final, ack && round != 0 && round == nr);
            check("kw_out_valid", bus.out_valid, 0);
            check("kw_in_ready", bus.in_ready, 0);
            if (ack) round++;
            else stalls++;
            step();
        end
        // DONE: a stray ack must not produce strobes
        bus.rk_ack = 1'b1;
        #1;
        check("done_out_valid", bus.out_valid, 1);
        check("done_rk_req", bus.rk_req, 0);
        check("done_dp_any", {bus.dp_load, bus.dp_round_en, bus.dp_final}, 0);
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("hs_busy", bus.busy, 1);
        step();
        bus.out_ready = 1'b0;
        bus.rk_ack    = 1'b0;
        #1;
        check("post_out_valid", bus.out_valid, 0);
        check("post_in_ready", bus.in_ready, 1);
        check("post_busy", bus.busy, 0);
    endtask

    initial begin
        int stuck_bad;
        n_tests = 0;
        n_fail  = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.key_len   = 3'b000;
        bus.rk_ack    = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_rk_req", bus.rk_req, 0);
        check("rst_rk_idx", bus.rk_idx, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_err", bus.err, 0);
        reset = 1'b0;
        step();
        check("idle_in_ready", bus.in_ready, 1);

        // AES-128 with no stalls and an immediate consumer
        run_block(3'b001, 10, -1, 0, 0);
        // AES-256 with a 3-cycle ack stall at round 5
        run_block(3'b100, 14, 5, 3, 0);
        // AES-192 plain
        run_block(3'b010, 12, -1, 0, 0);
        // Priority decode: 011 -> 192-bit
        run_block(3'b011, 12, -1, 0, 0);
        // AES-128 with consumer back-pressure for 5 cycles
        run_block(3'b001, 10, -1, 0, 5);

        // Invalid key length
        bus.in_valid = 1'b1;
        bus.key_len  = 3'b000;
        #1;
        check("inv_in_ready", bus.in_ready, 1);
        check("inv_err_early", bus.err, 0);
        step();
        bus.in_valid = 1'b0;
        #1;
        check("inv_err", bus.err, 1);
        check("inv_busy", bus.busy, 0);
        check("inv_rk_req", bus.rk_req, 0);
        check("inv_in_ready2", bus.in_ready, 1);
        step();
        check("inv_err_once", bus.err, 0);

        // Reset in the middle of an AES-192 block at round 6
        bus.in_valid = 1'b1;
        bus.key_len  = 3'b010;
        bus.rk_ack   = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("mid_rk_idx", bus.rk_idx, 6);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.rk_ack = 1'b0;
        #1;
        check("abort_rk_req", bus.rk_req, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_in_ready", bus.in_ready, 1);
        stuck_bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) stuck_bad++;
        end
        check("abort_quiet", stuck_bad, 0);
        run_block(3'b001, 10, -1, 0, 0);

        // Ack withheld at round 3
        bus.in_valid = 1'b1;
        bus.key_len  = 3'b001;
        bus.rk_ack   = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        bus.rk_ack = 1'b0;
        #1;
        check("stall_rk_idx", bus.rk_idx, 3);
        stuck_bad = 0;
`ifdef AES_RC_TIMEOUT_EN
        for (int i = 0; i < 64; i++) begin
            if (bus.busy !== 1'b1 || bus.rk_idx !== 4'd3 || bus.err !== 1'b0) stuck_bad++;
            step();
        end
        check("to_waiting", stuck_bad, 0);
        check("to_busy", bus.busy, 0);
        check("to_err", bus.err, 1);
        check("to_out_valid", bus.out_valid, 0);
        step();
        check("to_err_once", bus.err, 0);
`else
        for (int i = 0; i < 200; i++) begin
            if (bus.busy !== 1'b1 || bus.rk_idx !== 4'd3 || bus.err !== 1'b0) stuck_bad++;
            step();
        end
        check("wait_forever", stuck_bad, 0);
        check("wait_busy", bus.busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
`endif
        run_block(3'b100, 14, -1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Round sequencer for the iterative AES encryption datapath (initial AddRoundKey, then SubBytes/ShiftRows/MixColumns/AddRoundKey per round).
- Accepts a block request via valid/ready and derives the round count from key_len.
- Requests one round key per round from the key-expansion unit and strobes the datapath load, round-enable and final-round (MixColumns bypass) controls.
- Presents a result-valid handshake to the consumer.

Parameters:
- TIMEOUT_CYCLES, 64: round-key wait limit in cycles, range 2..255; used only when AES_RC_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- in_valid  in  1  block request; plaintext and key are stable while high
- in_ready  out  1  controller can accept a request
- key_len  in  3  key size select: bit2 = 256-bit (Nr=14), else bit1 = 192-bit (Nr=12), else bit0 = 128-bit (Nr=10), 000 = invalid
- rk_req  out  1  round key request
- rk_idx  out  4  round key index requested, 0..Nr
- rk_ack  in  1  round key for rk_idx present this cycle
- dp_load  out  1  datapath loads plaintext^rk0
- dp_round_en  out  1  datapath registers the round result
- dp_final  out  1  current round bypasses MixColumns
- out_valid  out  1  ciphertext register valid
- out_ready  in  1  consumer takes the ciphertext
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse: invalid key_len consumed, or timeout

Behaviour:
- Reset: all outputs are 0 except in_ready = 1; state = IDLE, round = 0, Nr = 0. A reset asserted mid-operation aborts the operation; no out_valid is produced and the next cycle is IDLE.

State IDLE:
- in_ready = 1.
- in_valid with key_len != 0: latch Nr (priority bit2 > bit1 > bit0), set round = 0, go to KEY_WAIT.
- in_valid with key_len == 0: request is consumed, err pulses the next cycle, state stays IDLE.
- key_len is sampled only on acceptance; later changes are ignored.

State KEY_WAIT:
- rk_req = 1 and rk_idx = round.
- rk_req, rk_idx and round hold while rk_ack = 0.
- rk_ack is ignored when rk_req = 0.

Datapath strobes (combinational in the cycle rk_req & rk_ack):
- round == 0: dp_load = 1.
- round != 0: dp_round_en = 1.
- dp_final = (round == Nr) & dp_round_en.
- At most one of dp_load and dp_round_en is high in any cycle.

Transitions on rk_ack:
- round < Nr: round increments and the state stays KEY_WAIT.
- round == Nr: go to DONE.
- round is never wrapped; with rk_idx 4 bits, 14 is the maximum value.

State DONE:
- out_valid = 1 and in_ready = 0.
- out_valid holds until out_ready; on out_valid & out_ready go to IDLE.
- The next request is accepted no earlier than the cycle after the handshake.

Latency:
- With rk_ack tied 1, acceptance at cycle T gives out_valid at T+Nr+2: 12 cycles for AES-128, 14 for AES-192, 16 for AES-256.
- Each cycle with rk_ack = 0 adds one cycle.

Optional Feature:
- AES_RC_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to KEY_WAIT and on each rk_ack, and increments every KEY_WAIT cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack, the next cycle is IDLE with err pulsing.
  - No out_valid is produced for the aborted block.
- AES_RC_TIMEOUT_EN undefined: no counter, and KEY_WAIT waits indefinitely; err pulses only for an invalid key_len.

Test Plan:
- key_len=001, rk_ack tied 1, out_ready=1: accept at T.
  - rk_idx steps 0..10 over T+1..T+11.
  - dp_load at T+1; dp_round_en at T+2..T+11; dp_final only at T+11.
  - out_valid at T+12 for one cycle.
- key_len=100, rk_ack low for 3 cycles at round 5: rk_idx holds at 5 for 4 cycles; dp_final at round 14; out_valid at T+19 (16+3).
- key_len=000 with in_valid: in_ready stays 1; err=1 for exactly one cycle; no rk_req; busy stays 0.
- AES-128 with out_ready=0 for 5 cycles after out_valid: out_valid stays high 6 cycles; in_ready=0 throughout; IDLE the cycle after the handshake.
- key_len=010, reset asserted at round 6:
  - Next cycle: rk_req=0, busy=0, in_ready=1, out_valid never asserted.
  - A following AES-128 request completes in 12 cycles.
- With AES_RC_TIMEOUT_EN and TIMEOUT_CYCLES=64, rk_ack held 0 at round 3: after 64 KEY_WAIT cycles the state is IDLE and err pulses once; without the macro, busy remains 1 for 200 cycles.
